// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target with a parametrised register file and read-back.
// Writes commit atomically on chip-select release; reads shift out on CIPO.
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int SYNC_FF  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_CMDL = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]  NREGS    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  state_t state, state_n;

  logic [SYNC_FF-1:0] sclk_sync, copi_sync, ncs_sync;
  logic               sclk_d, ncs_d;
  logic               sclk_s, copi_s, ncs_s;
  logic               sclk_rise, sclk_fall;
  logic               ncs_rise, ncs_fall;

  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] shreg;
  logic [DATA_W-1:0]  tx;
  logic               rd_mode;

  logic               pend;
  logic [ADDR_W-1:0]  pend_addr;
  logic [DATA_W-1:0]  pend_data;

  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [ADDR_W:0]    cmd_word;
  logic [DATA_W-1:0]  rd_val;
  logic               load_rd;
  logic               f_rw;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic               commit;

  // ncs chain resets low so a chip select held low at release is not a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_FF-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_FF-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_FF-2:0], ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_FF-1];
  assign copi_s    = copi_sync[SYNC_FF-1];
  assign ncs_s     = ncs_sync[SYNC_FF-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  assign cmd_word = {shreg[ADDR_W-1:0], copi_s};
  assign f_rw     = shreg[FRAME_W-1];
  assign f_addr   = shreg[DATA_W +: ADDR_W];
  assign f_data   = shreg[DATA_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_word[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (ncs_fall) state_n = CMD;
      CMD:  if (sclk_rise && cnt == CNT_CMDL) state_n = DATA;
      DATA: if (sclk_rise && cnt == CNT_LAST) state_n = DONE;
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (ncs_rise) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  assign load_rd = (state == CMD) && sclk_rise && (cnt == CNT_CMDL) &&
                   !cmd_word[ADDR_W] && !ncs_rise;

  assign commit = ncs_rise && (state == DONE) && (cnt == CNT_FULL) &&
                  f_rw && ({1'b0, f_addr} < NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      tx        <= '0;
      rd_mode   <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      pend      <= commit;
      wr_strobe <= pend;
      if (state == IDLE && ncs_fall) begin
        cnt     <= '0;
        shreg   <= '0;
        rd_mode <= 1'b0;
      end else if (state != IDLE && sclk_rise) begin
        if (cnt != CNT_OVER) cnt <= cnt + 1'b1;
        if (state != DONE) shreg <= {shreg[FRAME_W-2:0], copi_s};
      end
      // first fall after the load keeps the MSB on the wire for bit ADDR_W+1
      if (load_rd) begin
        tx      <= rd_val;
        rd_mode <= 1'b1;
      end else if (state == DATA && sclk_fall && cnt > CNT_CMD) begin
        tx <= {tx[DATA_W-2:0], 1'b0};
      end
      if (commit) begin
        pend_addr <= f_addr;
        pend_data <= f_data;
      end
      if (pend) wr_addr <= pend_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (pend) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (pend_addr == ADDR_W'(i)) regs[i] <= pend_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  assign cipo    = (state == DATA) && rd_mode && tx[DATA_W-1];
  assign cipo_oe = (state != IDLE);

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral with a write/read scoreboard.
// Expected writes and read bytes are queued at stimulus time and popped on output.
module tb_spi_regfile_peripheral;

  localparam int NR = 5;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int H  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sclk = 1'b0;
  logic           copi = 1'b0;
  logic           ncs = 1'b1;
  logic           cipo;
  logic           cipo_oe;
  logic [NR*DW-1:0] regs_flat;
  logic           wr_strobe;
  logic [AW-1:0]  wr_addr;

  spi_regfile_peripheral #(
    .NUM_REGS(NR),
    .ADDR_W(AW),
    .DATA_W(DW),
    .SYNC_FF(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs),
    .cipo(cipo),
    .cipo_oe(cipo_oe),
    .regs_flat(regs_flat),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t          wr_q [$];
  logic [DW-1:0] rd_q [$];
  logic [DW-1:0] mdl [NR];
  int           checks = 0;
  int           errors = 0;
  logic         strobe_prev = 1'b0;
  wr_t          e;

  function automatic logic [NR*DW-1:0] mflat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] bits, input int n,
                       input bit end_it, input int gap,
                       output logic [DW-1:0] rd);
    int k;
    rd = '0;
    ncs = 1'b0;
    wait_clk(H);
    for (int i = n - 1; i >= 0; i--) begin
      k = n - 1 - i;
      copi = bits[i];
      wait_clk(H);
      if (k == 0) chk("cipo_oe_frame", cipo_oe, 1);
      if (k >= AW + 1 && k < 1 + AW + DW) rd = {rd[DW-2:0], cipo};
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
    end
    if (end_it) begin
      wait_clk(H);
      ncs = 1'b1;
      wait_clk(gap);
    end
  endtask

  // write-side scoreboard: every strobe must match the oldest queued write
  always @(negedge clk) begin
    if (wr_strobe) begin
      chk("strobe_width", strobe_prev, 0);
      chk("strobe_expected", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        mdl[e.a] = e.d;
        chk("wr_addr", wr_addr, e.a);
        chk("regs_on_strobe", regs_flat, mflat());
      end
    end
    strobe_prev = wr_strobe;
  end

  initial begin
    logic [DW-1:0] rd;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    wait_clk(3);
    chk("rst_regs", regs_flat, 0);
    chk("rst_cipo", cipo, 0);
    chk("rst_cipo_oe", cipo_oe, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    rst_n = 1'b1;
    wait_clk(5);

    // single write
    wr_q.push_back('{a: 7'd4, d: 8'h01});
    frame(32'h8401, 16, 1, 10, rd);
    chk("t1_q_empty", wr_q.size(), 0);
    chk("t1_regs", regs_flat, mflat());
    chk("t1_wr_addr", wr_addr, 4);

    // write then read back
    wr_q.push_back('{a: 7'd2, d: 8'hA5});
    frame(32'h82A5, 16, 1, 10, rd);
    rd_q.push_back(mdl[2]);
    frame(32'h0200, 16, 1, 10, rd);
    chk("t2_read", rd, rd_q.pop_front());
    chk("t2_read_lit", rd, 8'hA5);
    rd_q.push_back(mdl[4]);
    frame(32'h0400, 16, 1, 10, rd);
    chk("t2_read4", rd, rd_q.pop_front());
    chk("t2_regs", regs_flat, mflat());
    chk("t2_cipo_idle", cipo, 0);

    // out-of-range write and read
    frame(32'h89FF, 16, 1, 10, rd);
    rd_q.push_back(8'h00);
    frame(32'h0900, 16, 1, 10, rd);
    chk("t3_read", rd, rd_q.pop_front());
    chk("t3_regs", regs_flat, mflat());

    // short then overlong frame
    frame(32'h815A >> 6, 10, 1, 10, rd);
    chk("t4_short_regs", regs_flat, mflat());
    frame({15'd0, 16'h815A, 1'b1}, 17, 1, 10, rd);
    chk("t4_long_regs", regs_flat, mflat());
    chk("t4_q_empty", wr_q.size(), 0);

    // back-to-back writes with one-clock chip-select gap
    for (int i = 0; i < NR; i++) begin
      wr_q.push_back('{a: AW'(i), d: DW'(8'h10 + 8'h11 * i)});
      frame({16'd0, 1'b1, AW'(i), DW'(8'h10 + 8'h11 * i)}, 16, 1, 1, rd);
    end
    wait_clk(12);
    chk("t6_q_empty", wr_q.size(), 0);
    chk("t6_regs", regs_flat, 40'h5443322110);

    // async reset in the middle of a write
    frame(32'h8177 >> 6, 10, 0, 0, rd);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_regs", regs_flat, 0);
    chk("t5_rst_cipo_oe", cipo_oe, 0);
    chk("t5_rst_wr_addr", wr_addr, 0);
    chk("t5_rst_strobe", wr_strobe, 0);
    chk("t5_rst_cipo", cipo, 0);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    ncs = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    wr_q.push_back('{a: 7'd0, d: 8'h33});
    frame(32'h8033, 16, 1, 10, rd);
    chk("t5_q_empty", wr_q.size(), 0);
    chk("t5_regs", regs_flat, 40'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
